// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_TIMEOUT = 65535;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: search starts just after last_grant_i
// and wraps, so the previous owner has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_grant_i,
  output logic [GW-1:0]      winner_o,
  output logic               any_valid_o
);

  localparam int SW = GW + 1;

  logic [SW-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    winner_o    = '0;
    any_valid_o = |req_i;
    cand        = '0;
    // Walk from the farthest offset down so the nearest valid candidate is written last.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = SW'(last_grant_i) + SW'(off);
      if (cand >= SW'(NUM_REQ)) begin
        cand = cand - SW'(NUM_REQ);
      end
      if (req_i[cand[GW-1:0]]) begin
        winner_o = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding one UART transmitter from NUM_REQ
// byte requesters, with an idle-while-locked force release.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_req,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_pulse
);

  localparam int GW = $clog2(NUM_REQ);

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tpulse_q, tpulse_d;

  logic [GW-1:0]    winner;
  logic             any_valid;
  logic             owner_valid;
  logic             accept;
  logic             timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .winner_o     (winner),
    .any_valid_o  (any_valid)
  );

  assign owner_valid = req_valid[grant_q];
  // A tx_ready with the owner's valid low is not an acceptance.
  assign accept      = (state_q == ST_SEND) && tx_ready && owner_valid;
  assign timeout_hit = (state_q == ST_SEND) && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= GW'(NUM_REQ - 1);
      cnt_q    <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tpulse_q <= tpulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tpulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_valid) begin
          grant_d = winner;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Acceptance outranks a coincident timeout.
        if (accept) begin
          cnt_d = '0;
          if (req_last[grant_q]) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end else if (timeout_hit) begin
          state_d  = ST_IDLE;
          last_d   = grant_q;
          cnt_d    = '0;
          tpulse_d = 1'b1;
        end else if (owner_valid) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_req    = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    if (state_q == ST_SEND) begin
      tx_req             = owner_valid;
      tx_data            = req_data[{grant_q, 3'b000} +: 8];
      req_ready[grant_q] = accept;
    end
  end

  assign busy          = (state_q == ST_SEND);
  assign grant_id      = grant_q;
  assign timeout_pulse = tpulse_q;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 65535: idle-while-locked release limit, in clk cycles (1..65535).
REQ-003 SHALL have port clk  in  1: single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ: per-requester byte-valid.
REQ-006 SHALL have port req_data  in  8*NUM_REQ: byte for requester i at [8i+7:8i].
REQ-007 SHALL have port req_last  in  NUM_REQ: marks the final byte of requester i's packet.
REQ-008 SHALL have port req_ready  out  NUM_REQ: one-cycle pulse when requester i's byte is accepted.
REQ-009 SHALL have port tx_req  out  1: byte request to the UART transmitter.
REQ-010 SHALL have port tx_data  out  8: byte presented to the UART transmitter.
REQ-011 SHALL have port tx_ready  in  1: one-cycle acceptance pulse from the UART transmitter.
REQ-012 SHALL have port busy  out  1: high while a packet owns the UART.
REQ-013 SHALL have port grant_id  out  clog2(NUM_REQ): index of the current or most recent owner.
REQ-014 SHALL have port timeout_pulse  out  1: one-cycle pulse when a lock is force-released.

Function
REQ-015 SHALL implement two states: IDLE and SEND.
REQ-016 In IDLE with any req_valid high, SHALL register the round-robin winner into grant_id and enter SEND on the next edge; this is 1 cycle of arbitration latency.
REQ-017 Round-robin search SHALL start at last_grant+1 and wrap modulo NUM_REQ; last_grant itself SHALL have lowest priority.
REQ-018 In SEND, tx_req SHALL equal req_valid[grant_id] and tx_data SHALL equal req_data[grant_id], combinationally; in IDLE both SHALL be 0.
REQ-019 req_ready[grant_id] SHALL equal tx_ready AND state==SEND, combinationally; all other req_ready bits SHALL be 0.
REQ-020 tx_ready arriving in IDLE, or while tx_req is low, SHALL be ignored.
REQ-021 Requesters SHALL hold data and last stable while valid is high until req_ready; the block SHALL not buffer bytes.
REQ-022 A lock SHALL persist across bytes: non-last accepted bytes keep SEND with the same grant_id.
REQ-023 When a byte with req_last=1 is accepted, SHALL go to IDLE, set last_grant=grant_id, and leave grant_id unchanged.
REQ-024 In the cycle after a packet ends, other pending requesters SHALL be arbitrated, so back-to-back packets have 1 idle cycle between owner changes.
REQ-025 Other requesters' valids SHALL never preempt a lock.
REQ-026 In SEND, a 16-bit counter SHALL increment each cycle req_valid[grant_id] is low and clear when it is high.
REQ-027 On reaching TIMEOUT, SHALL go to IDLE, set last_grant=grant_id, pulse timeout_pulse for 1 cycle, and clear the counter.
REQ-028 If tx_ready and the timeout occur in the same cycle, acceptance SHALL take precedence; a last byte ends the packet normally with no timeout_pulse.
REQ-029 busy SHALL be 1 exactly when state==SEND.

Reset
REQ-030 On reset, SHALL set state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), timeout counter=0, and timeout_pulse=0.
REQ-031 Reset asserted mid-packet SHALL abort the lock immediately; outputs tx_req, req_ready, and busy SHALL be 0 in the following cycle, and no partial-packet state SHALL be retained.

Structure
REQ-032 State encodings and the default NUM_REQ/TIMEOUT values SHALL live in the shared UART constants include.
REQ-033 SHALL contain one sub-module, rr_pick: combinational round-robin picker with inputs req vector and last_grant, and outputs winner index and any_valid.
REQ-034 SHALL use a single always block for state, grant, last_grant, and counter, with combinational output muxing.

Verification
REQ-035 Bench SHALL cover single-requester packets: after reset, req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> grant_id=0, three req_ready[0] pulses, busy drops the cycle after the third tx_ready.
REQ-036 Bench SHALL cover fairness: all 4 valid with 1-byte packets -> grant order 0,1,2,3,0; each owner change occurs 1 cycle after tx_ready.
REQ-037 Bench SHALL cover lock hold: req1 packet 0x10,0x11 with req2 valid throughout -> no req_ready[2] until 0x11 is accepted, then grant_id=2.
REQ-038 Bench SHALL cover timeout: with TIMEOUT=16, req3 sends a non-last byte then drops valid -> timeout_pulse 16 cycles later, busy=0, next grant starts from requester 0.
REQ-039 Bench SHALL cover reset mid-packet: reset during SEND of req2 -> next cycle tx_req=0 and busy=0; first subsequent grant goes to the lowest-index valid requester.
REQ-040 Bench SHALL cover simultaneous events: tx_ready on a last byte coinciding with the timeout count -> normal end, timeout_pulse stays 0.
